// File: rtl/button_conditioner.sv
// button_conditioner: 2-flop sync, per-channel debounce and press-edge pulse for push buttons.
// Latency: a level stable from sampling edge E is committed to held/pressed_pulse after edge E+DEBOUNCE_CYCLES+1.
// No backpressure: pressed_pulse is a one-cycle strobe. Auto-repeat is built only with BUTTON_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int                   N_BUTTONS       = 7,
  parameter int                   DEBOUNCE_CYCLES = 500000,
  parameter bit                   ACTIVE_LOW      = 1'b1,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = N_BUTTONS'(7'b0011110),
  parameter int                   REPEAT_DELAY    = 25000000,
  parameter int                   REPEAT_PERIOD   = 5000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] raw_buttons,
  output logic [N_BUTTONS-1:0] pressed_pulse,
  output logic [N_BUTTONS-1:0] held,
  output logic                 any_pressed
);

  // Counter needs to reach DEBOUNCE_CYCLES-1; DEBOUNCE_CYCLES >= 2 keeps this at least 1 bit.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Pin levels normalized so that 1 always means "pressed".
  logic [N_BUTTONS-1:0] norm;
  assign norm = raw_buttons ^ {N_BUTTONS{ACTIVE_LOW}};

  logic [N_BUTTONS-1:0]            sync1_q, sync2_q;
  logic [N_BUTTONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_BUTTONS-1:0]            held_q, held_d;
  logic [N_BUTTONS-1:0]            pulse_q, pulse_d;
  logic [N_BUTTONS-1:0]            press_commit, release_commit;

  // Two-stage synchronizer; resets to "released" so nothing is seen pressed out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= norm;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that disagree with held; commit after DEBOUNCE_CYCLES of them.
  always_comb begin
    cnt_d          = cnt_q;
    held_d         = held_q;
    press_commit   = '0;
    release_commit = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (sync2_q[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        held_d[i]         = sync2_q[i];
        cnt_d[i]          = '0;
        press_commit[i]   = sync2_q[i];
        release_commit[i] = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  // Repeat counter spans whichever of delay/period is longer.
  localparam int               RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RPT_W    = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [N_BUTTONS-1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  // rpt_phase_q: 0 = waiting out the initial delay, 1 = emitting at the period rate.
  logic [N_BUTTONS-1:0]            rpt_phase_q, rpt_phase_d;
  logic [N_BUTTONS-1:0]            rpt_fire;

  // Repeat timing: restart on any commit or while released; the release commit edge never fires.
  always_comb begin
    rpt_cnt_d   = rpt_cnt_q;
    rpt_phase_d = rpt_phase_q;
    rpt_fire    = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (!REPEAT_MASK[i] || !held_q[i] || press_commit[i] || release_commit[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_phase_d[i] = 1'b0;
      end else if (rpt_cnt_q[i] == (rpt_phase_q[i] ? PER_LAST : DLY_LAST)) begin
        rpt_fire[i]    = 1'b1;
        rpt_cnt_d[i]   = '0;
        rpt_phase_d[i] = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
      end
    end
  end

  // Repeat counter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= '0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  // Press pulses and repeat pulses share the output strobe.
  always_comb begin
    pulse_d = press_commit | (rpt_fire & REPEAT_MASK);
  end
`else
  // Keeps the repeat parameters referenced in builds without auto-repeat.
  logic cfg_unused;
  assign cfg_unused = (|REPEAT_MASK) ^ (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);

  // One strobe per accepted press only.
  always_comb begin
    pulse_d = press_commit;
  end
`endif

  // Debounce counters, committed level and registered pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      held_q  <= '0;
      pulse_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  assign pressed_pulse = pulse_q;
  assign held          = held_q;
  assign any_pressed   = |held_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized button activity,
// all outputs compared every cycle against a sample-window reference model.
module tb_button_conditioner;
  localparam int             N       = 7;
  localparam int             DEB     = 4;
  localparam bit             ACT_LOW = 1'b1;
  localparam logic [N-1:0]   RMASK   = 7'b0011110;
  localparam int             RDLY    = 20;
  localparam int             RPER    = 8;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit             REP_EN  = 1'b1;
`else
  localparam bit             REP_EN  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] raw_buttons;
  logic [N-1:0] pressed_pulse;
  logic [N-1:0] held;
  logic         any_pressed;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: committed level, expected strobe, and per-edge pressed samples.
  logic [N-1:0] m_held;
  logic [N-1:0] m_pulse;
  int           m_edge;
  int           m_commit_t [N];
  logic [N-1:0] hist [$];

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BUTTONS       (N),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (ACT_LOW),
    .REPEAT_MASK     (RMASK),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .raw_buttons   (raw_buttons),
    .pressed_pulse (pressed_pulse),
    .held          (held),
    .any_pressed   (any_pressed)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Two leading released samples stand for the synchronizer's reset contents.
  function automatic void model_clear();
    m_held  = '0;
    m_pulse = '0;
    m_edge  = 0;
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    for (int i = 0; i < N; i++) m_commit_t[i] = 0;
  endfunction

  // A channel commits when the last DEB synchronized samples all disagree with its level.
  // Repeats: DUT-visible pulses at commit+RDLY+k*RPER while the press is continuously held.
  function automatic void model_edge(input logic [N-1:0] raw_now);
    logic [N-1:0] nh, np;
    int           sz, d;
    bit           commit;
    hist.push_back(raw_now ^ {N{ACT_LOW}});
    sz = hist.size();
    nh = m_held;
    np = '0;
    for (int i = 0; i < N; i++) begin
      commit = (sz - 3 - (DEB - 1)) >= 0;
      for (int j = 0; j < DEB; j++) begin
        if (commit) begin
          if (hist[sz-3-j][i] == m_held[i]) commit = 1'b0;
        end
      end
      if (commit) begin
        nh[i] = ~m_held[i];
        if (!m_held[i]) begin
          np[i] = 1'b1;
          m_commit_t[i] = m_edge;
        end
      end else if (REP_EN && RMASK[i] && m_held[i]) begin
        d = m_edge - m_commit_t[i];
        if (d >= RDLY && ((d - RDLY) % RPER) == 0) np[i] = 1'b1;
      end
    end
    m_held  = nh;
    m_pulse = np;
    m_edge++;
  endfunction

  // One clock: model advances on the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (reset) model_edge(raw_buttons);
    @(negedge clk);
    check("pulse", 32'(pressed_pulse), 32'(m_pulse));
    check("held", 32'(held), 32'(m_held));
    check("any", 32'(any_pressed), 32'(|m_held));
  endtask

  task automatic run_until_pulse(input int idx, input int max, output int n);
    n = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (pressed_pulse[idx]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic run_until_released(input int idx, input int max, output int n, output int pulses);
    n = 0;
    pulses = 0;
    for (int k = 1; k <= max; k++) begin
      step();
      if (pressed_pulse[idx]) pulses++;
      if (!held[idx]) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic release_all();
    raw_buttons = '1;
    repeat (DEB + 6) step();
  endtask

  initial begin
    int n, cnt, first, last, pulses;
    bit noisy;

    reset       = 1'b0;
    raw_buttons = '1;
    model_clear();
    #1;
    check("rst_pulse", 32'(pressed_pulse), 32'd0);
    check("rst_held", 32'(held), 32'd0);
    check("rst_any", 32'(any_pressed), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    repeat (3) step();

    // 1: single press on left
    raw_buttons[2] = 1'b0;
    run_until_pulse(2, 20, n);
    check("t1_latency", 32'(n), 32'(DEB + 2));
    check("t1_pulse_val", 32'(pressed_pulse), 32'h04);
    step();
    check("t1_pulse_once", 32'(pressed_pulse[2]), 32'd0);
    check("t1_held", 32'(held[2]), 32'd1);
    check("t1_any", 32'(any_pressed), 32'd1);
    release_all();

    // 2: bounce shorter than the debounce window
    raw_buttons[0] = 1'b0;
    repeat (3) step();
    raw_buttons[0] = 1'b1;
    cnt = 0;
    repeat (10) begin
      step();
      cnt += int'(pressed_pulse[0]) + int'(held[0]);
    end
    check("t2_glitch", 32'(cnt), 32'd0);

    // 3: press and release start
    raw_buttons[6] = 1'b0;
    run_until_pulse(6, 20, n);
    check("t3_latency", 32'(n), 32'(DEB + 2));
    cnt = 0;
    repeat (24) begin
      step();
      cnt += int'(pressed_pulse[6]);
    end
    check("t3_single", 32'(cnt), 32'd0);
    raw_buttons[6] = 1'b1;
    run_until_released(6, 20, n, pulses);
    check("t3_rel_latency", 32'(n), 32'(DEB + 2));
    check("t3_rel_nopulse", 32'(pulses), 32'd0);
    release_all();

    // 4: simultaneous presses
    raw_buttons[1] = 1'b0;
    raw_buttons[3] = 1'b0;
    run_until_pulse(1, 20, n);
    check("t4_latency", 32'(n), 32'(DEB + 2));
    check("t4_pulse_val", 32'(pressed_pulse), 32'h0A);
    release_all();

    // 5: long hold on up (repeat-eligible) and start (never repeats)
    raw_buttons[3] = 1'b0;
    run_until_pulse(3, 20, n);
    cnt = 0; first = -1; last = -1;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (pressed_pulse[3]) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("t5_rep_count", 32'(cnt), REP_EN ? 32'd4 : 32'd0);
    check("t5_rep_first", 32'(first), REP_EN ? 32'd20 : 32'(-1));
    check("t5_rep_last", 32'(last), REP_EN ? 32'd44 : 32'(-1));
    release_all();
    raw_buttons[6] = 1'b0;
    run_until_pulse(6, 20, n);
    cnt = 0;
    repeat (50) begin
      step();
      cnt += int'(pressed_pulse[6]);
    end
    check("t5_start_norep", 32'(cnt), 32'd0);
    release_all();

    // 6: reset while down is held, button still pressed on deassert
    raw_buttons[4] = 1'b0;
    run_until_pulse(4, 20, n);
    repeat (5) step();
    check("t6_held_before", 32'(held[4]), 32'd1);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("t6_rst_pulse", 32'(pressed_pulse), 32'd0);
    check("t6_rst_held", 32'(held), 32'd0);
    check("t6_rst_any", 32'(any_pressed), 32'd0);
    repeat (2) step();
    reset = 1'b1;
    run_until_pulse(4, 20, n);
    check("t6_repress_latency", 32'(n), 32'(DEB + 2));
    release_all();

    // Randomized activity: alternating calm (long holds) and noisy (bouncy) stretches
    noisy = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) noisy = ~noisy;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, noisy ? 2 : 40) == 0) raw_buttons[i] = ~raw_buttons[i];
      end
      step();
    end
    release_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
